// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 receiver: sync, clock deglitch, 11-bit frame deserialiser
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with even parity are dropped.
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  logic                  c_s1_q, c_s1_d, c_s2_q, c_s2_d;
  logic                  d_s1_q, d_s1_d, d_s2_q, d_s2_d;
  logic [FILTER_LEN-1:0] flt_sr_q, flt_sr_d;
  logic                  filt_q, filt_d, filt_prev_q, filt_prev_d;
  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [9:0]            shreg_q, shreg_d;
  logic [7:0]            dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic fall_tick;
  logic stop_ok;
  logic par_ok;

  assign fall_tick = filt_prev_q & ~filt_q;
  assign stop_ok   = shreg_q[9];

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity over data and parity bit.
  assign par_ok = ^shreg_q[8:0];
`else
  // Parity bit is captured but does not affect acceptance.
  assign par_ok = shreg_q[8] | 1'b1;
`endif

  // Two-flop synchronisers and the ps2c level filter with falling-edge history.
  always_comb begin
    c_s1_d      = ps2c;
    c_s2_d      = c_s1_q;
    d_s1_d      = ps2d;
    d_s2_d      = d_s1_q;
    flt_sr_d    = {flt_sr_q[FILTER_LEN-2:0], c_s2_q};
    filt_d      = filt_q;
    if (&flt_sr_q) begin
      filt_d = 1'b1;
    end else if (~|flt_sr_q) begin
      filt_d = 1'b0;
    end
    filt_prev_d = filt_q;
  end

  // Frame FSM: start detection, bit shifting, inter-edge timeout and final check.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    timer_d   = timer_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall_tick && rx_en && !d_s2_q) begin
          state_d   = S_RECV;
          bit_cnt_d = 4'd9;
          timer_d   = '0;
        end
      end
      S_RECV: begin
        if (fall_tick) begin
          shreg_d = {d_s2_q, shreg_q[9:1]};
          timer_d = '0;
          if (bit_cnt_q == 4'd0) begin
            state_d = S_CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end else if (timer_q == TIMER_LAST) begin
          // The device stopped clocking mid-frame; abandon it.
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (timer_q != {TW{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (stop_ok && par_ok) begin
          dout_d = shreg_q[7:0];
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state, including registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_s1_q      <= 1'b1;
      c_s2_q      <= 1'b1;
      d_s1_q      <= 1'b1;
      d_s2_q      <= 1'b1;
      flt_sr_q    <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      timer_q     <= '0;
      shreg_q     <= '0;
      dout_q      <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      c_s1_q      <= c_s1_d;
      c_s2_q      <= c_s2_d;
      d_s1_q      <= d_s1_d;
      d_s2_q      <= d_s2_d;
      flt_sr_q    <= flt_sr_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rx_done_tick = done_q;
  assign dout         = dout_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - scoreboard bench for ps2_rx_frame
module tb_ps2_rx_frame;

  localparam int FL   = 8;
  localparam int TO   = 200;
  localparam int HALF = 40;

  // Kinds of expected outcome for a frame.
  localparam int K_DONE    = 0;
  localparam int K_ERR     = 1;
  localparam int K_NONE    = 2;
  localparam int K_TIMEOUT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       frame_err;

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rx_done_tick(rx_done_tick), .dout(dout), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] last_good = 8'h00;

  function automatic void check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endfunction

  // Monitor: every output pulse must match the oldest expected outcome.
  always @(negedge clk) begin
    if (rst_n && (rx_done_tick || frame_err)) begin
      exp_t e;
      check("pulses_exclusive", int'(rx_done_tick & frame_err), 0);
      check("pulse_was_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pulse_kind_is_err", int'(frame_err), int'(e.is_err));
        check("dout", int'(dout), int'(e.data));
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expected pulses pending", exp_q.size());
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends the first nfall bits of a frame; optional ps2c glitch in the high
  // phase before bit glitch_bit, optional rx_en drop after bit rxoff_bit.
  task automatic send(input logic [7:0] data, input bit par, input bit stop,
                      input int nfall, input int glitch_bit, input int rxoff_bit,
                      input int kind);
    logic [10:0] bits;
    int          fall_cyc;
    exp_t        e;
    bits = {stop, par, data, 1'b0};
    for (int i = 0; i < nfall; i++) begin
      ps2d = bits[i];
      if (i == glitch_bit) begin
        wait_clk(15);
        ps2c = 1'b0;
        wait_clk(FL - 1);
        ps2c = 1'b1;
        wait_clk(HALF - 15 - (FL - 1));
      end else begin
        wait_clk(HALF);
      end
      ps2c = 1'b0;
      fall_cyc = cyc;
      if (i == nfall - 1) begin
        if (kind == K_DONE) begin
          e.is_err = 1'b0; e.data = data; e.at = fall_cyc + FL + 5;
          last_good = data;
          exp_q.push_back(e);
        end else if (kind == K_ERR) begin
          e.is_err = 1'b1; e.data = last_good; e.at = fall_cyc + FL + 5;
          exp_q.push_back(e);
        end else if (kind == K_TIMEOUT) begin
          e.is_err = 1'b1; e.data = last_good; e.at = fall_cyc + FL + 4 + TO;
          exp_q.push_back(e);
        end
      end
      if (i == rxoff_bit) rx_en = 1'b0;
      wait_clk(HALF);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
  endtask

  task automatic frame(input logic [7:0] data, input bit par, input bit stop, input int kind);
    send(data, par, stop, 11, -1, -1, kind);
    wait_clk(60);
  endtask

  initial begin
    wait_clk(5);
    check("reset_dout", int'(dout), 0);
    check("reset_rx_done_tick", int'(rx_done_tick), 0);
    check("reset_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;
    wait_clk(30);

    // Single good frame.
    frame(8'h1C, 1'b0, 1'b1, K_DONE);
    // Back-to-back good frames.
    frame(8'hF0, 1'b1, 1'b1, K_DONE);
    frame(8'h1C, 1'b0, 1'b1, K_DONE);
    frame(8'hF0, 1'b1, 1'b1, K_DONE);
    // Bad parity on 0x1C.
`ifdef PS2_PARITY_CHECK_EN
    frame(8'h1C, 1'b1, 1'b1, K_ERR);
`else
    frame(8'h1C, 1'b1, 1'b1, K_DONE);
`endif
    // Stop bit 0 then a good 0x29.
    frame(8'h29, 1'b0, 1'b0, K_ERR);
    frame(8'h29, 1'b0, 1'b1, K_DONE);
    // rx_en low for a whole frame: ignored.
    rx_en = 1'b0;
    frame(8'h5A, 1'b1, 1'b1, K_NONE);
    rx_en = 1'b1;
    // rx_en dropped mid-frame: still completes.
    send(8'h5A, 1'b1, 1'b1, 11, -1, 3, K_DONE);
    wait_clk(60);
    rx_en = 1'b1;
    // Clock stalls after 5 falls: timeout, then a good 0x5A.
    send(8'h5A, 1'b1, 1'b1, 5, -1, -1, K_TIMEOUT);
    wait_clk(TO + 60);
    frame(8'h5A, 1'b1, 1'b1, K_DONE);
    // Short ps2c glitch in IDLE (data low) and in RECV.
    send(8'h1C, 1'b0, 1'b1, 11, 0, -1, K_DONE);
    wait_clk(60);
    send(8'hF0, 1'b1, 1'b1, 11, 4, -1, K_DONE);
    wait_clk(60);
    // Reset mid-frame: partial frame discarded silently.
    send(8'h29, 1'b0, 1'b1, 4, -1, -1, K_NONE);
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    last_good = 8'h00;
    check("dout_after_reset", int'(dout), 0);
    wait_clk(40);
    frame(8'h29, 1'b0, 1'b1, K_DONE);
    // A stop error after reset must keep the new byte.
    frame(8'h1C, 1'b0, 1'b0, K_ERR);

    wait_clk(100);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
